vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the VGA example. It counts pixels and lines from a
//  divided clk, and drives coord_x/coord_y/active_area into the downstream pattern
//  (graphics) stage. It also drives hsync/vsync to the connector, delayed so they line
//  up with that stage's registered rgb. Default timing is 640x480@60 from 50 MHz clk.
// PARAMETERS
//  CLK_DIV    2    clk cycles per pixel (>=1); pix_tick period
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BP       33   vertical back porch (lines)
//  SYNC_POL   0    0: syncs active-low, 1: active-high
//  SYNC_DELAY 1    clk cycles of delay on hsync/vsync vs coords (0..4)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  pix_tick     out  1   1-clk pulse, last clk of each pixel period
//  coord_x      out  10  horizontal counter, 0..H_TOTAL-1
//  coord_y      out  10  vertical counter, 0..V_TOTAL-1
//  active_area  out  1   1 when coord_x<H_ACTIVE and coord_y<V_ACTIVE
//  line_start   out  1   1-clk pulse when coord_x wraps to 0
//  frame_start  out  1   1-clk pulse when (coord_x,coord_y) wraps to (0,0)
//  hsync        out  1   horizontal sync, polarity per SYNC_POL, delayed SYNC_DELAY
//  vsync        out  1   vertical sync, polarity per SYNC_POL, delayed SYNC_DELAY
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Elaboration error if H_TOTAL>1024 or V_TOTAL>1024.
//  - Reset state (async): div, coord_x, coord_y = 0; active_area, pix_tick,
//    line_start, frame_start = 0; hsync/vsync = inactive level (~SYNC_POL);
//    sync delay pipeline filled with the inactive level.
//  - Divider: div counts 0..CLK_DIV-1 and wraps. pix_tick is registered and is high
//    while div==CLK_DIV-1. With CLK_DIV=1, pix_tick stays high.
//  - On each clk edge where div==CLK_DIV-1:
//    - coord_x += 1.
//    - At H_TOTAL-1, coord_x wraps to 0 and coord_y += 1.
//    - If coord_y is also at V_TOTAL-1, coord_y wraps to 0.
//  - Coords hold for CLK_DIV clk cycles each. The downstream stage may sample on any clk.
//  - active_area is registered and computed from the next-state counters, so it always
//    matches the coord_x/coord_y currently on the outputs. The first edge after reset
//    release sets it to 1 at (0,0).
//  - line_start / frame_start are high for exactly the one clk following a wrap.
//    They are not asserted for the (0,0) position held after reset.
//  - Raw hsync: active while H_ACTIVE+H_FP <= coord_x < H_ACTIVE+H_FP+H_SYNC.
//    Raw vsync: active while V_ACTIVE+V_FP <= coord_y < V_ACTIVE+V_FP+V_SYNC.
//  - hsync/vsync outputs are raw syncs passed through a SYNC_DELAY-stage clk shift
//    register. SYNC_DELAY=0 means registered with no extra delay. The default of 1
//    matches the one-clk rgb register of the downstream stage.
//  - Sync level is XORed with ~SYNC_POL at the final register only.
//  - Order within a line is: active, FP, sync, BP. The same order applies to lines.
//  - Reset asserted mid-frame: all state returns to reset values immediately.
//    After release, counting restarts at (0,0) with no partial frame_start.
//  - No inputs besides clk/reset; the block free-runs and never stalls.
// TESTING
//  1. Reset held 5 clk, then released -> coords 0,0; hsync=vsync=1; pix_tick pulses
//     every 2nd clk; active_area=1 after first edge.
//  2. Run 1600 clk -> coord_x steps 0..799, then wraps to 0; coord_y=1;
//     line_start high exactly 1 clk.
//  3. Line 0 -> hsync low for exactly 192 clk, starting 2 clk after coord_x becomes 656
//     (SYNC_DELAY=1 plus registered sync); active_area=0 from coord_x=640 to 799.
//  4. Full frame of 840000 clk -> coord_y wraps 524->0; frame_start one pulse;
//     vsync low for 3200 clk during lines 490-491.
//  5. Assert reset at coord (300,200) for 1 clk -> outputs return to reset values
//     asynchronously; no frame_start on restart.
//  6. CLK_DIV=1, SYNC_POL=1, SYNC_DELAY=0 -> pix_tick constant 1; line=800 clk;
//     hsync high for 96 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters from a divided clock, active-area flag,
// wrap pulses and delayed, polarity-adjusted hsync/vsync.
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] coord_x,
    output logic [9:0] coord_y,
    output logic       active_area,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0]      HA       = 11'(H_ACTIVE);
    localparam logic [10:0]      VA       = 11'(V_ACTIVE);
    localparam logic [10:0]      HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]      VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]      VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    // bit 1 = vsync, bit 0 = hsync; inactive output level for each
    localparam logic [1:0]       INV      = (SYNC_POL != 0) ? 2'b00 : 2'b11;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_param
        $error("vga_timing_gen: CLK_DIV must be >=1 and SYNC_DELAY within 0..4");
    end

    logic [DIV_W-1:0] div_r, div_next_s;
    logic [9:0]       coord_x_r, coord_y_r, x_next_s, y_next_s;
    logic             pix_tick_r, active_r, line_start_r, frame_start_r;
    logic             tick_s, line_wrap_s, frame_wrap_s;
    logic [1:0]       sync_raw_s;
    logic [1:0]       sync_in_s   [0:SYNC_DELAY];
    logic [1:0]       sync_pipe_r [0:SYNC_DELAY];

    // Next-state divider and raster counters, plus raw sync decode from current coords
    always_comb begin
        tick_s       = (div_r == DIV_LAST);
        div_next_s   = div_r;
        x_next_s     = coord_x_r;
        y_next_s     = coord_y_r;
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        if (tick_s) begin
            div_next_s = '0;
            if (coord_x_r == H_LAST) begin
                x_next_s    = 10'd0;
                line_wrap_s = 1'b1;
                if (coord_y_r == V_LAST) begin
                    y_next_s     = 10'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    y_next_s = coord_y_r + 10'd1;
                end
            end else begin
                x_next_s = coord_x_r + 10'd1;
            end
        end else begin
            div_next_s = div_r + DIV_W'(1);
        end
        sync_raw_s[0] = ({1'b0, coord_x_r} >= HS_START) && ({1'b0, coord_x_r} < HS_END);
        sync_raw_s[1] = ({1'b0, coord_y_r} >= VS_START) && ({1'b0, coord_y_r} < VS_END);
    end

    // Counter state and per-clk status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r         <= '0;
            coord_x_r     <= 10'd0;
            coord_y_r     <= 10'd0;
            pix_tick_r    <= 1'b0;
            active_r      <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= div_next_s;
            coord_x_r     <= x_next_s;
            coord_y_r     <= y_next_s;
            pix_tick_r    <= (div_next_s == DIV_LAST);
            active_r      <= ({1'b0, x_next_s} < HA) && ({1'b0, y_next_s} < VA);
            line_start_r  <= line_wrap_s;
            frame_start_r <= frame_wrap_s;
        end
    end

    assign sync_in_s[0] = sync_raw_s;
    for (genvar g = 1; g <= SYNC_DELAY; g++) begin : g_sync_link
        assign sync_in_s[g] = sync_pipe_r[g-1];
    end

    // Sync delay line; the last stage applies output polarity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= SYNC_DELAY; i++) begin
                sync_pipe_r[i] <= (i == SYNC_DELAY) ? INV : 2'b00;
            end
        end else begin
            for (int i = 0; i <= SYNC_DELAY; i++) begin
                sync_pipe_r[i] <= (i == SYNC_DELAY) ? (sync_in_s[i] ^ INV) : sync_in_s[i];
            end
        end
    end

    assign pix_tick    = pix_tick_r;
    assign coord_x     = coord_x_r;
    assign coord_y     = coord_y_r;
    assign active_area = active_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign hsync       = sync_pipe_r[SYNC_DELAY][0];
    assign vsync       = sync_pipe_r[SYNC_DELAY][1];

endmodule
